// File: rtl/nes_poll_scheduler.sv
// nes_poll_scheduler: APB3 poller for two NES pads sharing one latch/clock pair.
// Define NES_DEBOUNCE_EN to publish only bits that agree across two polls.
module nes_poll_scheduler #(
    parameter int LATCH_CYC  = 12,
    parameter int HALF_CYC   = 6,
    parameter int PERIOD_RST = 1666667
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        latch,
    output logic        clock,
    input  logic        data0,
    input  logic        data1,
    output logic        irq
);
    typedef enum logic [2:0] {
        IDLE, LATCH, SAMPLE, CLK_HI, CLK_LO, DONE_ST
    } state_t;

    localparam logic [15:0] LATCH_LAST = 16'(LATCH_CYC - 1);
    localparam logic [15:0] HALF_LAST  = 16'(HALF_CYC - 1);

    state_t      state;
    logic        en, auto_en, irq_en;
    logic [23:0] period, timer, period_m1;
    logic [15:0] pad, edges, raw, pad_new;
    logic        done, pending;
    logic [7:0]  sh0, sh1;
    logic [2:0]  bitcnt;
    logic [15:0] cnt;
    logic        wr, wr_ctrl, wr_period, wr_status, wr_edge;
    logic        tick, start, trig, abort, finish;
    logic        unused_wdata;

    assign wr        = PSEL & PENABLE & PWRITE;
    assign wr_ctrl   = wr & (PADDR == 8'h00);
    assign wr_period = wr & (PADDR == 8'h04);
    assign wr_status = wr & (PADDR == 8'h08);
    assign wr_edge   = wr & (PADDR == 8'h10);

    assign period_m1 = (period == 24'd0) ? 24'd0 : period - 24'd1;
    assign tick      = en & auto_en & (timer == period_m1);
    assign start     = wr_ctrl & PWDATA[8] & PWDATA[0];
    assign trig      = tick | start;
    assign abort     = wr_ctrl & ~PWDATA[0];
    assign finish    = (state == DONE_ST);
    assign raw       = {sh1, sh0};

    assign PREADY       = 1'b1;
    assign PSLVERR      = 1'b0;
    assign irq          = irq_en & done;
    assign unused_wdata = ^PWDATA[31:24];

`ifdef NES_DEBOUNCE_EN
    // A bit moves only when this poll agrees with the previous raw poll.
    logic [15:0] shadow;
    assign pad_new = (raw & ~(raw ^ shadow)) | (pad & (raw ^ shadow));

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN)
            shadow <= 16'd0;
        else if (finish)
            shadow <= raw;
    end
`else
    assign pad_new = raw;
`endif

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            en      <= 1'b0;
            auto_en <= 1'b0;
            irq_en  <= 1'b0;
            period  <= 24'(PERIOD_RST);
            timer   <= 24'd0;
        end else begin
            if (wr_ctrl) begin
                en      <= PWDATA[0];
                auto_en <= PWDATA[1];
                irq_en  <= PWDATA[2];
            end
            if (wr_period)
                period <= PWDATA[23:0];
            if (wr_period)
                timer <= 24'd0;
            else if (en & auto_en)
                timer <= tick ? 24'd0 : timer + 24'd1;
        end
    end

    // Hardware set is ORed in after the clear so a same-cycle W1C loses.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            pad   <= 16'd0;
            edges <= 16'd0;
            done  <= 1'b0;
        end else begin
            done  <= finish | (done & ~(wr_status & PWDATA[1]));
            edges <= (edges & ~(wr_edge ? PWDATA[15:0] : 16'd0))
                   | (finish ? (pad_new & ~pad) : 16'd0);
            if (finish)
                pad <= pad_new;
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state   <= IDLE;
            latch   <= 1'b0;
            clock   <= 1'b0;
            pending <= 1'b0;
            sh0     <= 8'd0;
            sh1     <= 8'd0;
            bitcnt  <= 3'd0;
            cnt     <= 16'd0;
        end else if (abort) begin
            state   <= IDLE;
            latch   <= 1'b0;
            clock   <= 1'b0;
            pending <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        state  <= LATCH;
                        latch  <= 1'b1;
                        cnt    <= 16'd0;
                        bitcnt <= 3'd0;
                    end
                end
                LATCH: begin
                    if (cnt == LATCH_LAST) begin
                        state <= SAMPLE;
                        latch <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SAMPLE: begin
                    sh0    <= {sh0[6:0], ~data0};
                    sh1    <= {sh1[6:0], ~data1};
                    bitcnt <= bitcnt + 3'd1;
                    cnt    <= 16'd0;
                    if (bitcnt == 3'd7) begin
                        state <= DONE_ST;
                    end else begin
                        state <= CLK_HI;
                        clock <= 1'b1;
                    end
                end
                CLK_HI: begin
                    if (cnt == HALF_LAST) begin
                        state <= CLK_LO;
                        clock <= 1'b0;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                CLK_LO: begin
                    if (cnt == HALF_LAST)
                        state <= SAMPLE;
                    else
                        cnt <= cnt + 16'd1;
                end
                DONE_ST: begin
                    if (pending | trig) begin
                        state   <= LATCH;
                        latch   <= 1'b1;
                        cnt     <= 16'd0;
                        bitcnt  <= 3'd0;
                        pending <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (trig && state != IDLE && state != DONE_ST)
                pending <= 1'b1;
        end
    end

    always_comb begin
        PRDATA = 32'd0;
        case (PADDR)
            8'h00:   PRDATA = {29'd0, irq_en, auto_en, en};
            8'h04:   PRDATA = {8'd0, period};
            8'h08:   PRDATA = {30'd0, done, state != IDLE};
            8'h0C:   PRDATA = {16'd0, pad};
            8'h10:   PRDATA = {16'd0, edges};
            default: PRDATA = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_nes_poll_scheduler.sv
// tb_nes_poll_scheduler: randomized bench with a button-level pad model.
// Expected PAD/EDGE/DONE come from per-poll button bytes, not DUT state.
`timescale 1ns/1ps
module tb_nes_poll_scheduler;
    localparam int LATCH_CYC  = 4;
    localparam int HALF_CYC   = 2;
    localparam int POLL       = LATCH_CYC + 8 + 14 * HALF_CYC + 1;
    localparam int PERIOD_RST = 1666667;

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b1;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [7:0]  PADDR = 8'd0;
    logic [31:0] PWDATA = 32'd0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, latch, clock, data0, data1, irq;

    int checks = 0;
    int failures = 0;
    int nlatch = 0;

    // Pad side: buttons (1 = pressed), A first; snapshot on latch rise.
    logic [7:0] btn0 = 8'd0, btn1 = 8'd0, snap0 = 8'd0, snap1 = 8'd0;
    int pidx = 8;

    logic [15:0] m_pad, m_edge, m_shadow;
    logic        m_done;

    nes_poll_scheduler #(
        .LATCH_CYC (LATCH_CYC),
        .HALF_CYC  (HALF_CYC),
        .PERIOD_RST(PERIOD_RST)
    ) dut (
        .PCLK   (PCLK),
        .PRESERN(PRESERN),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR),
        .latch  (latch),
        .clock  (clock),
        .data0  (data0),
        .data1  (data1),
        .irq    (irq)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge latch) begin
        snap0 = btn0;
        snap1 = btn1;
        pidx = 0;
        nlatch = nlatch + 1;
    end
    always @(posedge clock) pidx = pidx + 1;

    assign data0 = (pidx < 8) ? ~snap0[3'(7 - pidx)] : 1'b1;
    assign data1 = (pidx < 8) ? ~snap1[3'(7 - pidx)] : 1'b1;

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 d = PRDATA;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic model_reset();
        m_pad = 16'd0; m_edge = 16'd0; m_shadow = 16'd0; m_done = 1'b0;
    endtask

    // One completed poll of the current buttons.
    task automatic model_poll();
        logic [15:0] raw, np;
        raw = {btn1, btn0};
        np = raw;
`ifdef NES_DEBOUNCE_EN
        for (int b = 0; b < 16; b++)
            np[b] = (raw[b] == m_shadow[b]) ? raw[b] : m_pad[b];
        m_shadow = raw;
`endif
        for (int b = 0; b < 16; b++)
            if (np[b] && !m_pad[b]) m_edge[b] = 1'b1;
        m_pad = np;
        m_done = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        model_reset();
        #2 PRESERN = 1'b0;
        #1;
        checks++;
        if (latch !== 1'b0) begin failures++; $display("FAIL rst_latch got=%b exp=0", latch); end
        checks++;
        if (clock !== 1'b0) begin failures++; $display("FAIL rst_clock got=%b exp=0", clock); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
        repeat (2) @(negedge PCLK);
        PRESERN = 1'b1;
        apb_read(8'h00, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL rst_ctrl got=%h exp=0", d); end
        apb_read(8'h04, d);
        checks++;
        if (d !== 32'(PERIOD_RST)) begin failures++; $display("FAIL rst_period got=%h exp=%h", d, 32'(PERIOD_RST)); end
        apb_read(8'h08, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL rst_status got=%h exp=0", d); end
        apb_read(8'h0C, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL rst_pad got=%h exp=0", d); end
        apb_read(8'h10, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL rst_edge got=%h exp=0", d); end
        apb_read(8'h14, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL unmapped got=%h exp=0", d); end
        checks++;
        if (PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
            failures++; $display("FAIL apb_resp got=%b%b exp=10", PREADY, PSLVERR);
        end
    endtask

    task automatic test_first_poll();
        logic [31:0] d;
        int lat_hi = 0, lat_first = -1, rises = 0, clk_hi = 0, irq_at = -1;
        logic pc = 1'b0;
        btn0 = 8'h81; btn1 = 8'h00;
        apb_write(8'h00, 32'h105);
        for (int i = 0; i < 50; i++) begin
            if (latch) begin
                lat_hi++;
                if (lat_first < 0) lat_first = i;
            end
            if (clock) clk_hi++;
            if (clock && !pc) rises++;
            pc = clock;
            if (irq && irq_at < 0) irq_at = i;
            @(negedge PCLK);
        end
        model_poll();
        checks++;
        if (lat_first !== 0 || lat_hi !== LATCH_CYC) begin
            failures++; $display("FAIL latch_pulse got=%0d@%0d exp=%0d@0", lat_hi, lat_first, LATCH_CYC);
        end
        checks++;
        if (rises !== 7 || clk_hi !== 7 * HALF_CYC) begin
            failures++; $display("FAIL clk_pulses got=%0d/%0d exp=7/%0d", rises, clk_hi, 7 * HALF_CYC);
        end
        checks++;
        if (irq_at !== POLL) begin failures++; $display("FAIL poll_len got=%0d exp=%0d", irq_at, POLL); end
        apb_read(8'h0C, d);
        checks++;
        if (d !== {16'd0, m_pad}) begin failures++; $display("FAIL first_pad got=%h exp=%h", d, m_pad); end
        apb_read(8'h10, d);
        checks++;
        if (d !== {16'd0, m_edge}) begin failures++; $display("FAIL first_edge got=%h exp=%h", d, m_edge); end
        apb_read(8'h08, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL first_status got=%h exp=2", d); end
        apb_read(8'h00, d);
        checks++;
        if (d !== 32'h5) begin failures++; $display("FAIL ctrl_rb got=%h exp=5", d); end
    endtask

    task automatic test_w1c();
        logic [31:0] d;
        apb_write(8'h08, 32'h2);
        m_done = 1'b0;
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL w1c_irq got=%b exp=0", irq); end
        apb_write(8'h10, 32'h81);
        m_edge = m_edge & ~16'h0081;
        apb_read(8'h10, d);
        checks++;
        if (d !== {16'd0, m_edge}) begin failures++; $display("FAIL w1c_edge got=%h exp=%h", d, m_edge); end
        apb_write(8'h00, 32'h105);
        repeat (POLL) @(negedge PCLK);
        model_poll();
        apb_read(8'h10, d);
        checks++;
        if (d !== {16'd0, m_edge}) begin failures++; $display("FAIL repoll_edge got=%h exp=%h", d, m_edge); end
        btn1 = 8'h80;
        apb_write(8'h00, 32'h105);
        repeat (POLL) @(negedge PCLK);
        model_poll();
        apb_read(8'h10, d);
        checks++;
        if (d !== {16'd0, m_edge}) begin failures++; $display("FAIL pad1_edge got=%h exp=%h", d, m_edge); end
        apb_read(8'h0C, d);
        checks++;
        if (d !== {16'd0, m_pad}) begin failures++; $display("FAIL pad1_pad got=%h exp=%h", d, m_pad); end
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        apb_write(8'h08, 32'h2);
        m_done = 1'b0;
        apb_write(8'h00, 32'h105);
        repeat (POLL - 3) @(negedge PCLK);
        apb_write(8'h08, 32'h2);
        model_poll();
        apb_read(8'h08, d);
        checks++;
        if (d !== {30'd0, m_done, 1'b0}) begin failures++; $display("FAIL set_wins got=%h exp=2", d); end
    endtask

    task automatic test_start_disabled();
        logic [31:0] d;
        int n0;
        n0 = nlatch;
        apb_write(8'h00, 32'h100);
        repeat (50) @(negedge PCLK);
        apb_read(8'h08, d);
        checks++;
        if (nlatch - n0 !== 0 || d[0] !== 1'b0) begin
            failures++; $display("FAIL start_dis got=%0d/%b exp=0/0", nlatch - n0, d[0]);
        end
    endtask

    task automatic test_start_queue();
        logic [31:0] d;
        int n0;
        n0 = nlatch;
        apb_write(8'h00, 32'h101);
        repeat (3) apb_write(8'h00, 32'h101);
        repeat (120) @(negedge PCLK);
        model_poll();
        model_poll();
        checks++;
        if (nlatch - n0 !== 2) begin failures++; $display("FAIL queue_depth got=%0d exp=2", nlatch - n0); end
        apb_read(8'h0C, d);
        checks++;
        if (d !== {16'd0, m_pad}) begin failures++; $display("FAIL queue_pad got=%h exp=%h", d, m_pad); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int starts[$];
        logic pl = 1'b0;
        apb_write(8'h00, 32'h3);
        apb_write(8'h04, 32'd20);
        for (int i = 0; i < 200; i++) begin
            if (latch && !pl) starts.push_back(i);
            pl = latch;
            @(negedge PCLK);
        end
        apb_write(8'h00, 32'h0);
        m_done = 1'b1;
        checks++;
        if (starts.size() !== 5) begin failures++; $display("FAIL b2b_count got=%0d exp=5", starts.size()); end
        if (starts.size() > 0) begin
            checks++;
            if (starts[0] !== 20) begin failures++; $display("FAIL b2b_first got=%0d exp=20", starts[0]); end
        end
        for (int k = 1; k < starts.size(); k++) begin
            checks++;
            if (starts[k] - starts[k-1] !== POLL) begin
                failures++; $display("FAIL b2b_gap got=%0d exp=%0d", starts[k] - starts[k-1], POLL);
            end
        end
        apb_read(8'h04, d);
        checks++;
        if (d !== 32'd20) begin failures++; $display("FAIL period_rb got=%h exp=14", d); end
    endtask

    task automatic test_en_abort();
        logic [31:0] d;
        apb_write(8'h08, 32'h2);
        m_done = 1'b0;
        btn0 = ~btn0; btn1 = ~btn1;
        apb_write(8'h00, 32'h101);
        repeat (7) @(negedge PCLK);
        apb_write(8'h00, 32'h0);
        checks++;
        if (latch !== 1'b0 || clock !== 1'b0) begin
            failures++; $display("FAIL abort_pins got=%b%b exp=00", latch, clock);
        end
        apb_read(8'h08, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL abort_busy got=%h exp=0", d); end
        repeat (60) @(negedge PCLK);
        apb_read(8'h08, d);
        checks++;
        if (d !== {30'd0, m_done, 1'b0}) begin failures++; $display("FAIL abort_done got=%h exp=0", d); end
        apb_read(8'h0C, d);
        checks++;
        if (d !== {16'd0, m_pad}) begin failures++; $display("FAIL abort_pad got=%h exp=%h", d, m_pad); end
        apb_read(8'h10, d);
        checks++;
        if (d !== {16'd0, m_edge}) begin failures++; $display("FAIL abort_edge got=%h exp=%h", d, m_edge); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [15:0] mask;
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                btn0 = 8'($urandom);
                btn1 = 8'($urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                mask = 16'($urandom);
                apb_write(8'h10, {16'd0, mask});
                m_edge = m_edge & ~mask;
            end
            apb_write(8'h00, 32'h101);
            repeat (POLL) @(negedge PCLK);
            model_poll();
            apb_read(8'h08, d);
            checks++;
            if (d !== {30'd0, m_done, 1'b0}) begin failures++; $display("FAIL rnd_status it=%0d got=%h exp=2", it, d); end
            apb_read(8'h0C, d);
            checks++;
            if (d !== {16'd0, m_pad}) begin failures++; $display("FAIL rnd_pad it=%0d got=%h exp=%h", it, d, m_pad); end
            apb_read(8'h10, d);
            checks++;
            if (d !== {16'd0, m_edge}) begin failures++; $display("FAIL rnd_edge it=%0d got=%h exp=%h", it, d, m_edge); end
        end
    endtask

`ifdef NES_DEBOUNCE_EN
    task automatic poll_and_read(output logic [31:0] d);
        apb_write(8'h00, 32'h101);
        repeat (POLL) @(negedge PCLK);
        model_poll();
        apb_read(8'h0C, d);
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        btn0 = 8'h00;
        poll_and_read(d);
        poll_and_read(d);
        btn0 = 8'h80;
        poll_and_read(d);
        checks++;
        if (d[7] !== 1'b0 || d !== {16'd0, m_pad}) begin
            failures++; $display("FAIL db_glitch got=%h exp=%h", d, m_pad);
        end
        btn0 = 8'h00;
        poll_and_read(d);
        btn0 = 8'h80;
        poll_and_read(d);
        checks++;
        if (d[7] !== 1'b0) begin failures++; $display("FAIL db_first got=%h exp_bit7=0", d); end
        poll_and_read(d);
        checks++;
        if (d[7] !== 1'b1 || d !== {16'd0, m_pad}) begin
            failures++; $display("FAIL db_settle got=%h exp=%h", d, m_pad);
        end
    endtask
`endif

    task automatic test_reset_mid_poll();
        logic [31:0] d;
        apb_write(8'h00, 32'h105);
        checks++;
        if (latch !== 1'b1 || irq !== m_done) begin
            failures++; $display("FAIL pre_rst got=%b%b exp=1%b", latch, irq, m_done);
        end
        #2 PRESERN = 1'b0;
        #1;
        checks++;
        if (latch !== 1'b0 || clock !== 1'b0 || irq !== 1'b0) begin
            failures++; $display("FAIL mid_rst got=%b%b%b exp=000", latch, clock, irq);
        end
        model_reset();
        repeat (2) @(negedge PCLK);
        PRESERN = 1'b1;
        apb_read(8'h08, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL mid_rst_status got=%h exp=0", d); end
        apb_read(8'h0C, d);
        checks++;
        if (d !== {16'd0, m_pad}) begin failures++; $display("FAIL mid_rst_pad got=%h exp=0", d); end
    endtask

    initial begin
        test_reset();
        test_first_poll();
        test_w1c();
        test_set_wins();
        test_start_disabled();
        test_start_queue();
        test_back_to_back();
        test_en_abort();
        test_random();
`ifdef NES_DEBOUNCE_EN
        test_debounce();
`endif
        test_reset_mid_poll();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
